dt_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-cathode seven-segment digits, generalising the single-digit hex encoder to DIGITS digits behind one shared segment bus. It captures a packed hex word plus a per-digit blank mask, double-buffers it so the displayed frame never tears, and scans the digits with a programmable prescaler. It sits between the CPU debug/IO registers and the board display pins.

---
 rtl/dt_scan_driver.sv | 121 ++++++++++++
 tb/tb_dt_scan_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_scan_driver.sv
// Multiplexed seven-segment scan driver: DIGITS hex digits on one shared segment bus.
// Double-buffered frame capture; optional leading-zero blanking via DT_SCAN_LZB_EN.
module dt_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [DIGITS-1:0]     sel,
    output logic [0:6]            dt,
    output logic                  frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]       pcnt_reg, pcnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [4*DIGITS-1:0] pend_data_reg, pend_data_next;
    logic [DIGITS-1:0]   pend_blank_reg, pend_blank_next;
    logic [4*DIGITS-1:0] disp_data_reg, disp_data_next;
    logic [DIGITS-1:0]   disp_blank_reg, disp_blank_next;
    logic                tick, wrap;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   lzb;
    logic [DIGITS-1:0]   blank_eff;
    logic [DIGITS-1:0]   sel_next;
    logic [0:6]          dt_next;

    function automatic logic [0:6] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'b1111110;
            4'h1: seg_code = 7'b0110000;
            4'h2: seg_code = 7'b1101101;
            4'h3: seg_code = 7'b1111001;
            4'h4: seg_code = 7'b0110011;
            4'h5: seg_code = 7'b1011011;
            4'h6: seg_code = 7'b1011111;
            4'h7: seg_code = 7'b1110000;
            4'h8: seg_code = 7'b1111111;
            4'h9: seg_code = 7'b1111011;
            4'hA: seg_code = 7'b1110111;
            4'hB: seg_code = 7'b0011111;
            4'hC: seg_code = 7'b1001110;
            4'hD: seg_code = 7'b0111101;
            4'hE: seg_code = 7'b1001111;
            default: seg_code = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        tick      = (pcnt_reg == PCNT_LAST);
        wrap      = tick && (idx_reg == IDX_LAST);
        pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
        idx_next  = idx_reg;
        if (tick)
            idx_next = wrap ? '0 : idx_reg + 1'b1;
        pend_data_next  = load ? data  : pend_data_reg;
        pend_blank_next = load ? blank : pend_blank_reg;
        // A load coinciding with the wrap goes straight to the display buffer.
        disp_data_next  = wrap ? pend_data_next  : disp_data_reg;
        disp_blank_next = wrap ? pend_blank_next : disp_blank_reg;
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = disp_data_next[4*gi +: 4];
        end
    endgenerate

`ifdef DT_SCAN_LZB_EN
    // upper_zero[i]: nibble i and every nibble above it are zero.
    logic [DIGITS:1] upper_zero;
    assign upper_zero[DIGITS] = 1'b1;
    assign lzb[0]             = 1'b0;
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzb
            assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
            assign lzb[gi]        = upper_zero[gi];
        end
    endgenerate
`else
    assign lzb = '0;
`endif

    always_comb begin
        blank_eff = disp_blank_next | lzb;
        sel_next  = DIGITS'(1) << idx_next;
        dt_next   = blank_eff[idx_next] ? 7'b0000000 : seg_code(nib[idx_next]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_reg       <= '0;
            idx_reg        <= '0;
            pend_data_reg  <= '0;
            pend_blank_reg <= '0;
            disp_data_reg  <= '0;
            disp_blank_reg <= '0;
            sel            <= DIGITS'(1);
            dt             <= 7'b1111110;
            frame_tick     <= 1'b0;
        end else begin
            pcnt_reg       <= pcnt_next;
            idx_reg        <= idx_next;
            pend_data_reg  <= pend_data_next;
            pend_blank_reg <= pend_blank_next;
            disp_data_reg  <= disp_data_next;
            disp_blank_reg <= disp_blank_next;
            sel            <= sel_next;
            dt             <= dt_next;
            frame_tick     <= wrap;
        end
    end

endmodule

// File: tb/tb_dt_scan_driver.sv
// Directed bench for dt_scan_driver (DIGITS=4, SCAN_DIV=3); honours DT_SCAN_LZB_EN.
module tb_dt_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 3;

    localparam logic [0:6] C_ZERO = 7'b1111110;
    localparam logic [0:6] C_OFF  = 7'b0000000;
`ifdef DT_SCAN_LZB_EN
    localparam logic [0:6] Z_HI = 7'b0000000;
`else
    localparam logic [0:6] Z_HI = 7'b1111110;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data  = '0;
    logic [3:0]  blank = '0;
    logic        load  = 1'b0;
    logic [3:0]  sel;
    logic [0:6]  dt;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    logic [0:6] fr_dt  [4];
    logic [3:0] fr_sel [4];

    dt_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .blank(blank), .load(load),
        .sel(sel), .dt(dt), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Advance to the next negedge where frame_tick is high (strictly after now).
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            tests++; fails++;
            $display("FAIL frame_sync: frame_tick=%b after %0d cycles, required 1", frame_tick, n);
        end
    endtask

    task automatic grab_frame();
        wait_frame();
        for (int d = 0; d < DIGITS; d++) begin
            fr_dt[d]  = dt;
            fr_sel[d] = sel;
            repeat (SCAN_DIV) @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        data = d; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (sel !== 4'b0001 || dt !== C_ZERO || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: sel=%b dt=%b ft=%b, required 0001 1111110 0", sel, dt, frame_tick);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (sel !== 4'b0001 || dt !== C_ZERO || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: sel=%b dt=%b ft=%b, required 0001 1111110 0", sel, dt, frame_tick);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel;
        logic       exp_ft;
        rst_n = 1'b1;
        for (int n = 0; n < 26; n++) begin
            exp_sel = 4'b0001 << ((n / SCAN_DIV) % DIGITS);
            exp_ft  = (n > 0) && (n % (DIGITS * SCAN_DIV) == 0);
            tests++;
            if (sel !== exp_sel || frame_tick !== exp_ft) begin
                fails++;
                $display("FAIL scan_step%0d: sel=%b ft=%b, required %b %b", n, sel, frame_tick, exp_sel, exp_ft);
            end
            @(negedge clk);
        end
        $display("[TB] test_scan done");
    endtask

    task automatic test_load_midframe();
        logic [0:6] exp [4];
        exp[0] = 7'b1000111; exp[1] = 7'b1111001; exp[2] = 7'b1110111; exp[3] = 7'b0110000;
        wait_frame();
        repeat (4) @(negedge clk);
        do_load(16'h1A3F, 4'b0000);
        @(negedge clk);
        tests++;
        if (sel !== 4'b0100 || dt !== Z_HI) begin
            fails++;
            $display("FAIL midframe_d2: sel=%b dt=%b, required 0100 %b", sel, dt, Z_HI);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (sel !== 4'b1000 || dt !== Z_HI) begin
            fails++;
            $display("FAIL midframe_d3: sel=%b dt=%b, required 1000 %b", sel, dt, Z_HI);
        end
        grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            tests++;
            if (fr_dt[d] !== exp[d]) begin
                fails++;
                $display("FAIL load_1A3F_d%0d: dt=%b, required %b", d, fr_dt[d], exp[d]);
            end
        end
        $display("[TB] test_load_midframe done");
    endtask

    task automatic test_last_wins();
        wait_frame();
        @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        @(negedge clk);
        tests++;
        if (dt !== 7'b1110111) begin
            fails++;
            $display("FAIL last_wins_current: dt=%b, required 1110111", dt);
        end
        grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            tests++;
            if (fr_dt[d] !== 7'b1101101) begin
                fails++;
                $display("FAIL last_wins_d%0d: dt=%b, required 1101101", d, fr_dt[d]);
            end
        end
        $display("[TB] test_last_wins done");
    endtask

    task automatic test_wrap_load();
        wait_frame();
        repeat (DIGITS * SCAN_DIV - 1) @(negedge clk);
        data = 16'hEEEE; blank = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tests++;
        if (frame_tick !== 1'b1 || sel !== 4'b0001 || dt !== 7'b1001111) begin
            fails++;
            $display("FAIL wrap_load_d0: ft=%b sel=%b dt=%b, required 1 0001 1001111", frame_tick, sel, dt);
        end
        for (int d = 1; d < DIGITS; d++) begin
            repeat (SCAN_DIV) @(negedge clk);
            tests++;
            if (dt !== 7'b1001111) begin
                fails++;
                $display("FAIL wrap_load_d%0d: dt=%b, required 1001111", d, dt);
            end
        end
        grab_frame();
        tests++;
        if (fr_dt[0] !== 7'b1001111) begin
            fails++;
            $display("FAIL wrap_load_pending: dt=%b, required 1001111", fr_dt[0]);
        end
        $display("[TB] test_wrap_load done");
    endtask

    task automatic test_blank();
        logic [0:6] e;
        do_load(16'h8888, 4'b0100);
        grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            e = (d == 2) ? C_OFF : 7'b1111111;
            tests++;
            if (fr_dt[d] !== e || fr_sel[d] !== (4'b0001 << d)) begin
                fails++;
                $display("FAIL blank_d%0d: sel=%b dt=%b, required %b %b", d, fr_sel[d], fr_dt[d], 4'b0001 << d, e);
            end
        end
        $display("[TB] test_blank done");
    endtask

    task automatic test_lzb();
        logic [0:6] exp [4];
        exp[0] = C_ZERO; exp[1] = 7'b1011011; exp[2] = Z_HI; exp[3] = Z_HI;
        do_load(16'h0050, 4'b0000);
        grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            tests++;
            if (fr_dt[d] !== exp[d]) begin
                fails++;
                $display("FAIL lzb_0050_d%0d: dt=%b, required %b", d, fr_dt[d], exp[d]);
            end
        end
        do_load(16'h0000, 4'b0000);
        grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            tests++;
            if (fr_dt[d] !== ((d == 0) ? C_ZERO : Z_HI)) begin
                fails++;
                $display("FAIL lzb_0000_d%0d: dt=%b, required %b", d, fr_dt[d], (d == 0) ? C_ZERO : Z_HI);
            end
        end
        $display("[TB] test_lzb done");
    endtask

    task automatic test_reset_midframe();
        do_load(16'h9999, 4'b0000);
        wait_frame();
        repeat (2) @(negedge clk);
        do_load(16'h1234, 4'b0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (sel !== 4'b0001 || dt !== C_ZERO || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: sel=%b dt=%b ft=%b, required 0001 1111110 0", sel, dt, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            tests++;
            if (fr_dt[d] !== ((d == 0) ? C_ZERO : Z_HI)) begin
                fails++;
                $display("FAIL reset_discard_d%0d: dt=%b, required %b", d, fr_dt[d], (d == 0) ? C_ZERO : Z_HI);
            end
        end
        $display("[TB] test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_last_wins();
        test_wrap_load();
        test_blank();
        test_lzb();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
